// File: rtl/mem_channel_server.sv
// Purpose: multi-channel data-memory responder, one shared RAM, round-robin arbitration over ACCESS_PORTS.
// Latency: ready rises LATENCY edges after acceptance; read data is snapshotted at acceptance.
// Backpressure: ungranted requests wait in IDLE and retry; ready holds until the requester drops valid.
module mem_channel_server #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int ACCESS_PORTS = 1,
    parameter int LATENCY      = 2,
    parameter int STAT_BITS    = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] read_address,
    output logic [NUM_CHANNELS-1:0]           read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] read_data,
    input  logic [NUM_CHANNELS-1:0]           write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] write_data,
    output logic [NUM_CHANNELS-1:0]           write_ready,
    input  logic                              load_en,
    input  logic [ADDR_BITS-1:0]              load_addr,
    input  logic [DATA_BITS-1:0]              load_data,
    output logic [STAT_BITS-1:0]              read_count,
    output logic [STAT_BITS-1:0]              write_count
);

    localparam int PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state [NUM_CHANNELS];
    logic [CNT_W-1:0]        cnt   [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] op_wr;
    logic [DATA_BITS-1:0]    mem   [DEPTH];
    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        ptr_nxt;
    logic [NUM_CHANNELS-1:0] cand;
    logic [NUM_CHANNELS-1:0] grant;
    logic [NUM_CHANNELS-1:0] acc;
    logic [STAT_BITS:0]      n_rd;
    logic [STAT_BITS:0]      n_wr;
    logic [STAT_BITS:0]      rd_sum;
    logic [STAT_BITS:0]      wr_sum;

    // A channel competes for a port only while idle with any request pending
    always_comb begin
        cand = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            cand[c] = (state[c] == IDLE) && (read_valid[c] || write_valid[c]);
        end
    end

    // Round-robin grant of up to ACCESS_PORTS candidates starting at the pointer
    always_comb begin
        logic [PTR_W-1:0] idx;
        int               n_grant;
        grant   = '0;
        ptr_nxt = ptr;
        idx     = ptr;
        n_grant = 0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (cand[idx] && (n_grant < ACCESS_PORTS)) begin
                grant[idx] = 1'b1;
                n_grant    = n_grant + 1;
                ptr_nxt    = (idx == PTR_W'(NUM_CHANNELS - 1)) ? '0 : idx + 1'b1;
            end
            idx = (idx == PTR_W'(NUM_CHANNELS - 1)) ? '0 : idx + 1'b1;
        end
    end

    // Grants only take effect outside reset so a reset edge never commits a write
    assign acc = reset ? grant : '0;

    // Per-edge accepted read/write totals and their saturating sums
    always_comb begin
        n_rd = '0;
        n_wr = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (acc[c]) begin
                if (write_valid[c]) n_wr = n_wr + 1'b1;
                else                n_rd = n_rd + 1'b1;
            end
        end
        rd_sum = {1'b0, read_count} + n_rd;
        wr_sum = {1'b0, write_count} + n_wr;
    end

    // Shared RAM: later channel index overrides earlier, host load overrides all
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (acc[c] && write_valid[c]) begin
                mem[write_address[c*ADDR_BITS +: ADDR_BITS]] <= write_data[c*DATA_BITS +: DATA_BITS];
            end
        end
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // Read data snapshot at acceptance sees the pre-edge RAM contents
    always_ff @(posedge clk) begin
        if (!reset) begin
            read_data <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (acc[c] && !write_valid[c]) begin
                    read_data[c*DATA_BITS +: DATA_BITS] <= mem[read_address[c*ADDR_BITS +: ADDR_BITS]];
                end
            end
        end
    end

    // Arbitration pointer and saturating statistics
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr         <= '0;
            read_count  <= '0;
            write_count <= '0;
        end else begin
            ptr         <= ptr_nxt;
            read_count  <= rd_sum[STAT_BITS] ? {STAT_BITS{1'b1}} : rd_sum[STAT_BITS-1:0];
            write_count <= wr_sum[STAT_BITS] ? {STAT_BITS{1'b1}} : wr_sum[STAT_BITS-1:0];
        end
    end

    // Per-channel IDLE/WAIT/RESP sequencing with registered ready outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c] <= IDLE;
                cnt[c]   <= '0;
            end
            op_wr       <= '0;
            read_ready  <= '0;
            write_ready <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state[c])
                    IDLE: begin
                        if (grant[c]) begin
                            state[c] <= WAIT;
                            cnt[c]   <= CNT_W'(LATENCY - 1);
                            op_wr[c] <= write_valid[c];
                        end
                    end
                    WAIT: begin
                        if (cnt[c] == '0) begin
                            state[c] <= RESP;
                            if (op_wr[c]) write_ready[c] <= 1'b1;
                            else          read_ready[c]  <= 1'b1;
                        end else begin
                            cnt[c] <= cnt[c] - 1'b1;
                        end
                    end
                    RESP: begin
                        if (op_wr[c] ? !write_valid[c] : !read_valid[c]) begin
                            state[c]       <= IDLE;
                            write_ready[c] <= 1'b0;
                            read_ready[c]  <= 1'b0;
                        end
                    end
                    default: state[c] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_channel_server.sv
// Bench for mem_channel_server: directed scenarios plus randomized traffic against a RAM model.
// Instance a: 4 channels, one access port, 16-bit stats. Instance b: two access ports, 4-bit stats.
// Outputs are sampled 1 time unit after each rising edge.
module tb_mem_channel_server;

    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [N-1:0]    a_rv = '0, a_wv = '0, a_rr, a_wr;
    logic [N*AW-1:0] a_ra = '0, a_wa = '0;
    logic [N*DW-1:0] a_wd = '0, a_rd;
    logic            a_le = 1'b0;
    logic [AW-1:0]   a_la = '0;
    logic [DW-1:0]   a_ld = '0;
    logic [15:0]     a_rc, a_wc;

    logic [N-1:0]    b_rv = '0, b_wv = '0, b_rr, b_wr;
    logic [N*AW-1:0] b_ra = '0, b_wa = '0;
    logic [N*DW-1:0] b_wd = '0, b_rd;
    logic            b_le = 1'b0;
    logic [AW-1:0]   b_la = '0;
    logic [DW-1:0]   b_ld = '0;
    logic [3:0]      b_rc, b_wc;

    mem_channel_server #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CHANNELS(N),
                         .ACCESS_PORTS(1), .LATENCY(LAT), .STAT_BITS(16)) dut_a (
        .clk(clk), .reset(reset),
        .read_valid(a_rv), .read_address(a_ra), .read_ready(a_rr), .read_data(a_rd),
        .write_valid(a_wv), .write_address(a_wa), .write_data(a_wd), .write_ready(a_wr),
        .load_en(a_le), .load_addr(a_la), .load_data(a_ld),
        .read_count(a_rc), .write_count(a_wc)
    );

    mem_channel_server #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CHANNELS(N),
                         .ACCESS_PORTS(2), .LATENCY(LAT), .STAT_BITS(4)) dut_b (
        .clk(clk), .reset(reset),
        .read_valid(b_rv), .read_address(b_ra), .read_ready(b_rr), .read_data(b_rd),
        .write_valid(b_wv), .write_address(b_wa), .write_data(b_wd), .write_ready(b_wr),
        .load_en(b_le), .load_addr(b_la), .load_data(b_ld),
        .read_count(b_rc), .write_count(b_wc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic a_load(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        a_le = 1'b1; a_la = addr; a_ld = data;
        tick();
        a_le = 1'b0;
    endtask

    task automatic b_load(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        b_le = 1'b1; b_la = addr; b_ld = data;
        tick();
        b_le = 1'b0;
    endtask

    // Single read on instance a; ok stays 0 if ready never arrives
    task automatic a_read(input int c, input logic [AW-1:0] addr, output logic [DW-1:0] d, output bit ok);
        ok = 1'b0; d = '0;
        a_rv[c] = 1'b1; a_ra[c*AW +: AW] = addr;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (a_rr[c]) begin ok = 1'b1; d = a_rd[c*DW +: DW]; break; end
        end
        a_rv[c] = 1'b0;
        tick();
    endtask

    task automatic b_read(input int c, input logic [AW-1:0] addr, output logic [DW-1:0] d, output bit ok);
        ok = 1'b0; d = '0;
        b_rv[c] = 1'b1; b_ra[c*AW +: AW] = addr;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (b_rr[c]) begin ok = 1'b1; d = b_rd[c*DW +: DW]; break; end
        end
        b_rv[c] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (a_rr !== '0) begin errors++; $display("FAIL reset_a_read_ready: got %b expected 0", a_rr); end
        checks++; if (a_wr !== '0) begin errors++; $display("FAIL reset_a_write_ready: got %b expected 0", a_wr); end
        checks++; if (a_rd !== '0) begin errors++; $display("FAIL reset_a_read_data: got %h expected 0", a_rd); end
        checks++; if (a_rc !== 16'd0 || a_wc !== 16'd0) begin errors++; $display("FAIL reset_a_counts: got %0d/%0d expected 0/0", a_rc, a_wc); end
        checks++; if (b_rc !== 4'd0 || b_wc !== 4'd0 || b_rr !== '0 || b_wr !== '0) begin
            errors++; $display("FAIL reset_b_outputs: got rc=%0d wc=%0d rr=%b wr=%b expected all 0", b_rc, b_wc, b_rr, b_wr); end
    endtask

    task automatic test_basic_read();
        do_reset();
        for (int i = 0; i < 8; i++) a_load(AW'(i), DW'((i % 4) + 1));
        a_rv[0] = 1'b1; a_ra[7:0] = 8'd3;
        tick();
        checks++; if (a_rr[0] !== 1'b0) begin errors++; $display("FAIL basic_ready_E: got %b expected 0", a_rr[0]); end
        tick();
        checks++; if (a_rr[0] !== 1'b0) begin errors++; $display("FAIL basic_ready_E1: got %b expected 0", a_rr[0]); end
        tick();
        checks++; if (a_rr[0] !== 1'b1) begin errors++; $display("FAIL basic_ready_E2: got %b expected 1", a_rr[0]); end
        checks++; if (a_rd[7:0] !== 8'd4) begin errors++; $display("FAIL basic_data: got %0d expected 4", a_rd[7:0]); end
        tick();
        checks++; if (a_rr[0] !== 1'b1) begin errors++; $display("FAIL basic_ready_hold: got %b expected 1", a_rr[0]); end
        a_rv[0] = 1'b0;
        tick();
        checks++; if (a_rr[0] !== 1'b0) begin errors++; $display("FAIL basic_ready_drop: got %b expected 0", a_rr[0]); end
        checks++; if (a_rc !== 16'd1) begin errors++; $display("FAIL basic_read_count: got %0d expected 1", a_rc); end
    endtask

    task automatic test_round_robin();
        int rise [N];
        do_reset();
        for (int burst = 0; burst < 2; burst++) begin
            for (int c = 0; c < N; c++) begin
                rise[c] = -1; a_rv[c] = 1'b1; a_ra[c*AW +: AW] = AW'(c);
            end
            for (int k = 1; k <= 12; k++) begin
                tick();
                for (int c = 0; c < N; c++) begin
                    if (rise[c] < 0 && a_rr[c]) begin
                        rise[c] = k; a_rv[c] = 1'b0;
                        checks++;
                        if (a_rd[c*DW +: DW] !== DW'(c + 1)) begin
                            errors++; $display("FAIL rr_data ch%0d: got %0d expected %0d", c, a_rd[c*DW +: DW], c + 1); end
                    end
                end
            end
            for (int c = 0; c < N; c++) begin
                checks++;
                if (rise[c] != 3 + c) begin
                    errors++; $display("FAIL rr_order burst%0d ch%0d: ready edge %0d expected %0d", burst, c, rise[c], 3 + c); end
            end
        end
        checks++; if (a_rc !== 16'd8) begin errors++; $display("FAIL rr_read_count: got %0d expected 8", a_rc); end
    endtask

    task automatic test_rw_hazard();
        int wk, rk;
        logic [DW-1:0] d0, d1;
        bit ok;
        do_reset();
        b_load(8'd8, 8'd0);
        b_wv[1] = 1'b1; b_wa[1*AW +: AW] = 8'd8; b_wd[1*DW +: DW] = 8'd16;
        b_rv[2] = 1'b1; b_ra[2*AW +: AW] = 8'd8;
        wk = -1; rk = -1; d0 = '0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (wk < 0 && b_wr[1]) begin wk = k; b_wv[1] = 1'b0; end
            if (rk < 0 && b_rr[2]) begin rk = k; d0 = b_rd[2*DW +: DW]; b_rv[2] = 1'b0; end
        end
        checks++; if (wk != 3 || rk != 3) begin errors++; $display("FAIL hazard_same_edge: write edge %0d read edge %0d expected 3 and 3", wk, rk); end
        checks++; if (d0 !== 8'd0) begin errors++; $display("FAIL hazard_old_value: got %0d expected 0", d0); end
        b_read(2, 8'd8, d1, ok);
        checks++; if (!ok || d1 !== 8'd16) begin errors++; $display("FAIL hazard_new_value: got %0d ok=%0d expected 16", d1, ok); end
    endtask

    task automatic test_write_collision();
        int k0, k3;
        logic [DW-1:0] d;
        bit ok;
        do_reset();
        for (int round = 0; round < 2; round++) begin
            b_wv[0] = 1'b1; b_wa[0*AW +: AW] = 8'd10; b_wd[0*DW +: DW] = 8'd5;
            b_wv[3] = 1'b1; b_wa[3*AW +: AW] = 8'd10; b_wd[3*DW +: DW] = 8'd9;
            if (round == 1) begin b_le = 1'b1; b_la = 8'd10; b_ld = 8'd7; end
            k0 = -1; k3 = -1;
            for (int k = 1; k <= 10; k++) begin
                tick();
                b_le = 1'b0;
                if (k0 < 0 && b_wr[0]) begin k0 = k; b_wv[0] = 1'b0; end
                if (k3 < 0 && b_wr[3]) begin k3 = k; b_wv[3] = 1'b0; end
            end
            checks++; if (k0 != 3 || k3 != 3) begin errors++; $display("FAIL collide_same_edge round%0d: edges %0d/%0d expected 3/3", round, k0, k3); end
            b_read(1, 8'd10, d, ok);
            checks++;
            if (!ok || d !== ((round == 0) ? 8'd9 : 8'd7)) begin
                errors++; $display("FAIL collide_winner round%0d: got %0d expected %0d", round, d, (round == 0) ? 9 : 7); end
        end
    endtask

    task automatic test_rw_same_channel();
        int wk, rk;
        logic [DW-1:0] d;
        do_reset();
        a_rv[2] = 1'b1; a_ra[2*AW +: AW] = 8'd20;
        a_wv[2] = 1'b1; a_wa[2*AW +: AW] = 8'd20; a_wd[2*DW +: DW] = 8'd42;
        wk = -1; rk = -1; d = '0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (wk < 0 && a_wr[2]) begin
                wk = k; a_wv[2] = 1'b0;
                checks++; if (a_rr[2] !== 1'b0) begin errors++; $display("FAIL same_ch_read_early: got %b expected 0", a_rr[2]); end
            end
            if (rk < 0 && a_rr[2]) begin rk = k; d = a_rd[2*DW +: DW]; a_rv[2] = 1'b0; end
        end
        checks++; if (wk != 3) begin errors++; $display("FAIL same_ch_write_edge: got %0d expected 3", wk); end
        checks++; if (rk != 7) begin errors++; $display("FAIL same_ch_read_edge: got %0d expected 7", rk); end
        checks++; if (d !== 8'd42) begin errors++; $display("FAIL same_ch_read_data: got %0d expected 42", d); end
        checks++; if (a_wc !== 16'd1 || a_rc !== 16'd1) begin errors++; $display("FAIL same_ch_counts: got w=%0d r=%0d expected 1/1", a_wc, a_rc); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        bit ok;
        do_reset();
        a_wv[0] = 1'b1; a_wa[7:0] = 8'd30; a_wd[7:0] = 8'h5A;
        tick();
        checks++; if (a_wc !== 16'd1) begin errors++; $display("FAIL mid_accept_count: got %0d expected 1", a_wc); end
        reset = 1'b0; a_wv[0] = 1'b0;
        tick();
        checks++; if (a_wr !== '0 || a_rr !== '0) begin errors++; $display("FAIL mid_ready_cleared: got w=%b r=%b expected 0", a_wr, a_rr); end
        checks++; if (a_wc !== 16'd0 || a_rc !== 16'd0) begin errors++; $display("FAIL mid_counts_cleared: got w=%0d r=%0d expected 0", a_wc, a_rc); end
        tick();
        checks++; if (a_wr[0] !== 1'b0) begin errors++; $display("FAIL mid_no_late_ready: got %b expected 0", a_wr[0]); end
        reset = 1'b1;
        a_read(0, 8'd30, d, ok);
        checks++; if (!ok || d !== 8'h5A) begin errors++; $display("FAIL mid_write_kept: got %h ok=%0d expected 5a", d, ok); end
    endtask

    task automatic test_saturation();
        logic [DW-1:0] d;
        bit ok;
        int n_ok;
        do_reset();
        n_ok = 0;
        for (int i = 0; i < 20; i++) begin
            b_read(0, AW'(i), d, ok);
            if (ok) n_ok++;
            if (i == 13) begin
                checks++; if (b_rc !== 4'd14) begin errors++; $display("FAIL sat_count_14: got %0d expected 14", b_rc); end
            end
        end
        checks++; if (n_ok != 20) begin errors++; $display("FAIL sat_reads_served: got %0d expected 20", n_ok); end
        checks++; if (b_rc !== 4'd15) begin errors++; $display("FAIL sat_count_hold: got %0d expected 15", b_rc); end
    endtask

    // Random well-behaved masters; each channel owns one quarter of the address space
    task automatic test_random();
        logic [DW-1:0] model [256];
        int            phase [N];
        int            t0 [N];
        int            hold [N];
        bit            wr [N];
        logic [AW-1:0] ad [N];
        logic [DW-1:0] dt [N];
        int            n_rd, n_wr;
        bit            rdy;
        n_rd = 0; n_wr = 0;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            model[i] = DW'($urandom);
            a_load(AW'(i), model[i]);
        end
        for (int c = 0; c < N; c++) begin phase[c] = 0; t0[c] = 0; hold[c] = 0; wr[c] = 1'b0; ad[c] = '0; dt[c] = '0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                rdy = wr[c] ? a_wr[c] : a_rr[c];
                case (phase[c])
                    0: begin
                        if (cyc < 2800 && $urandom_range(0, 3) == 0) begin
                            wr[c] = 1'($urandom_range(0, 1));
                            ad[c] = AW'((c << 6) | int'($urandom_range(0, 63)));
                            dt[c] = DW'($urandom);
                            if (wr[c]) begin a_wv[c] = 1'b1; a_wa[c*AW +: AW] = ad[c]; a_wd[c*DW +: DW] = dt[c]; end
                            else begin a_rv[c] = 1'b1; a_ra[c*AW +: AW] = ad[c]; end
                            t0[c] = cyc; phase[c] = 1;
                        end
                    end
                    1: begin
                        if (rdy) begin
                            checks++;
                            if (cyc - t0[c] < LAT + 1 || cyc - t0[c] > LAT + N) begin
                                errors++; $display("FAIL rand_latency ch%0d: got %0d cycles expected %0d..%0d", c, cyc - t0[c], LAT + 1, LAT + N); end
                            if (wr[c]) begin
                                model[ad[c]] = dt[c]; n_wr++;
                            end else begin
                                n_rd++;
                                checks++;
                                if (a_rd[c*DW +: DW] !== model[ad[c]]) begin
                                    errors++; $display("FAIL rand_rdata ch%0d addr %0d: got %h expected %h", c, ad[c], a_rd[c*DW +: DW], model[ad[c]]); end
                            end
                            hold[c] = int'($urandom_range(0, 2));
                            if (hold[c] == 0) begin a_rv[c] = 1'b0; a_wv[c] = 1'b0; phase[c] = 3; end
                            else phase[c] = 2;
                        end else if (cyc - t0[c] > LAT + N) begin
                            checks++; errors++;
                            $display("FAIL rand_timeout ch%0d: no ready after %0d cycles expected <= %0d", c, cyc - t0[c], LAT + N);
                            a_rv[c] = 1'b0; a_wv[c] = 1'b0; phase[c] = 0;
                        end
                    end
                    2: begin
                        checks++;
                        if (rdy !== 1'b1) begin errors++; $display("FAIL rand_hold ch%0d: got %b expected 1", c, rdy); end
                        if (!wr[c]) begin
                            checks++;
                            if (a_rd[c*DW +: DW] !== model[ad[c]]) begin
                                errors++; $display("FAIL rand_rdata_stable ch%0d: got %h expected %h", c, a_rd[c*DW +: DW], model[ad[c]]); end
                        end
                        hold[c]--;
                        if (hold[c] == 0) begin a_rv[c] = 1'b0; a_wv[c] = 1'b0; phase[c] = 3; end
                    end
                    default: begin
                        checks++;
                        if ((a_rr[c] | a_wr[c]) !== 1'b0) begin
                            errors++; $display("FAIL rand_release ch%0d: got r=%b w=%b expected 0", c, a_rr[c], a_wr[c]); end
                        phase[c] = 0;
                    end
                endcase
            end
            tick();
        end
        checks++; if (a_rc !== 16'(n_rd)) begin errors++; $display("FAIL rand_read_count: got %0d expected %0d", a_rc, n_rd); end
        checks++; if (a_wc !== 16'(n_wr)) begin errors++; $display("FAIL rand_write_count: got %0d expected %0d", a_wc, n_wr); end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_round_robin();
        test_rw_hazard();
        test_write_collision();
        test_rw_same_channel();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
